karatsuba_seq_mul: RTL

//  Multi-cycle signed WIDTH x WIDTH -> 2*WIDTH multiplier built on Karatsuba decomposition.
//  Has one shared unsigned (HALF+1)x(HALF+1) multiplier, time-multiplexed over three products (z0, z2, z1) by an FSM.

---
 rtl/karatsuba_seq_mul.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/karatsuba_seq_mul.sv
// karatsuba_seq_mul
//   Multi-cycle signed WIDTH x WIDTH -> 2*WIDTH multiplier using Karatsuba.
//   A single unsigned (HALF+1)x(HALF+1) multiplier is shared across the three
//   partial products z0 = al*bl, z2 = ah*bh and p1 = (al+ah)*(bl+bh).
//   The three products are computed in successive FSM states. One operation
//   is in flight at a time.
// Ports
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready only in IDLE)
//   a, b                 signed two's complement operands
//   out_valid/out_ready  result handshake (result held until accepted)
//   result               exact signed product a*b
//   busy                 high whenever the FSM is not in IDLE
module karatsuba_seq_mul #(
    parameter int WIDTH = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               busy
);
    localparam int HALF = WIDTH / 2;
    localparam int PW   = 2 * HALF + 2;  // shared multiplier product width
    localparam int RW   = 2 * WIDTH;

    typedef enum logic [2:0] {IDLE, MUL_Z0, MUL_Z2, MUL_Z1, COMBINE, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_mag_q, a_mag_d, b_mag_q, b_mag_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] z0_q, z0_d, z2_q, z2_d;
    logic [PW-1:0]    p1_q, p1_d;
    logic [RW-1:0]    result_q, result_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [HALF-1:0]  al, ah, bl, bh;
    logic [HALF:0]    mul_a, mul_b;
    logic [PW-1:0]    mul_p;
    logic [PW-1:0]    mid;
    logic [RW-1:0]    mag;

    assign al = a_mag_q[HALF-1:0];
    assign ah = a_mag_q[WIDTH-1:HALF];
    assign bl = b_mag_q[HALF-1:0];
    assign bh = b_mag_q[WIDTH-1:HALF];

    // Operand mux selected by state only, so the multiplier inputs never
    // depend on the handshake inputs.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            MUL_Z0: begin mul_a = {1'b0, al};         mul_b = {1'b0, bl};         end
            MUL_Z2: begin mul_a = {1'b0, ah};         mul_b = {1'b0, bh};         end
            MUL_Z1: begin mul_a = {1'b0, al} + {1'b0, ah};
                          mul_b = {1'b0, bl} + {1'b0, bh}; end
            default: ;
        endcase
    end

    assign mul_p = PW'(mul_a) * PW'(mul_b);

    // Cross term p1 - z0 - z2 = al*bh + ah*bl, which is non-negative.
    // Every shifted term fits in 2*WIDTH bits (PW + HALF <= 2*WIDTH for
    // WIDTH >= 4), and the final magnitude is at most 2^(2*WIDTH-2). The sum
    // therefore never wraps at 2*WIDTH bits and is exact.
    assign mid = p1_q - PW'(z0_q) - PW'(z2_q);
    assign mag = (RW'(z2_q) << WIDTH) + (RW'(mid) << HALF) + RW'(z0_q);

    always_comb begin
        state_d     = state_q;
        a_mag_d     = a_mag_q;
        b_mag_d     = b_mag_q;
        sign_d      = sign_q;
        z0_d        = z0_q;
        z2_d        = z2_q;
        p1_d        = p1_q;
        result_d    = result_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: if (in_valid) begin
                // Negating the most-negative value yields 2^(WIDTH-1),
                // which is correct when read as unsigned.
                a_mag_d    = a[WIDTH-1] ? -a : a;
                b_mag_d    = b[WIDTH-1] ? -b : b;
                sign_d     = a[WIDTH-1] ^ b[WIDTH-1];
                state_d    = MUL_Z0;
                in_ready_d = 1'b0;
                busy_d     = 1'b1;
            end
            MUL_Z0: begin z0_d = mul_p[WIDTH-1:0]; state_d = MUL_Z2; end
            MUL_Z2: begin z2_d = mul_p[WIDTH-1:0]; state_d = MUL_Z1; end
            MUL_Z1: begin p1_d = mul_p;            state_d = COMBINE; end
            COMBINE: begin
                // Negating a zero magnitude gives zero, so there is no -0 case.
                result_d    = sign_q ? -mag : mag;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: if (out_ready) begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_mag_q     <= '0;
            b_mag_q     <= '0;
            sign_q      <= 1'b0;
            z0_q        <= '0;
            z2_q        <= '0;
            p1_q        <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_mag_q     <= a_mag_d;
            b_mag_q     <= b_mag_d;
            sign_q      <= sign_d;
            z0_q        <= z0_d;
            z2_q        <= z2_d;
            p1_q        <= p1_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = busy_q;
endmodule
